// File: rtl/rio_top.sv
// rio_top -- standalone I/O top for the Tang Primer 20K.
//   Heartbeat LED, three conditioned buttons mirrored on LED1..3, ENA on LED4,
//   joint-10 direction on LED5, DOUT11 = b2 & b3, and three free-running
//   step/dir generators (joints 8, 9, 10). There is no host link: motion runs at
//   a fixed rate and the buttons control it.
//   Optional feature: define RIO_DEBOUNCE_EN to filter each synchronized button
//   through a DEB_CYCLES stability window.
// Ports:
//   sysclk, sysrst_n        clock (rising edge) and async active-low reset
//   BUTTON1..3              raw active-high buttons (asynchronous)
//   BLINK_LED               heartbeat, toggles every BLINK_DIV cycles
//   LED1..LED3              conditioned BUTTON1..3; LED4 = ENA; LED5 = DIR10
//   DOUT11                  conditioned BUTTON2 & BUTTON3
//   ENA                     stepper enable, low while BUTTON1 (stop) is pressed
//   JOINTn_STEPPER_STP/DIR  step pulse and direction, n = 8, 9, 10

// Per-button conditioning: 2-FF synchronizer, optionally followed by a debouncer.
module rio_btn #(
  parameter int DEB_CYCLES = 270_000
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic pin,
  output logic b
);
`ifdef RIO_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif

  logic [1:0] sync;

  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n) sync <= '0;
    else         sync <= {sync[0], pin};

  generate
    if (DEB_EN) begin : g_deb
      localparam int DW = $clog2(DEB_CYCLES + 1);
      logic [DW-1:0] deb_cnt;
      logic          b_q;
      // Count consecutive cycles the synchronized input disagrees with the
      // filtered output; any agreement restarts the window.
      always_ff @(posedge gclk or negedge grst_n)
        if (!grst_n) begin
          deb_cnt <= '0;
          b_q     <= 1'b0;
        end else if (sync[1] == b_q) begin
          deb_cnt <= '0;
        end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
          deb_cnt <= '0;
          b_q     <= sync[1];
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      assign b = b_q;
    end else begin : g_raw
      assign b = sync[1];
    end
  endgenerate
endmodule

// One step/dir generator. TRAVEL > 0 selects ping-pong direction (toggle
// after TRAVEL steps); TRAVEL == 0 latches dir_in.
module rio_stepgen #(
  parameter int PERIOD     = 2700,
  parameter int STEP_PULSE = 54,
  parameter int TRAVEL     = 0
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic ena,
  input  logic dir_in,
  output logic stp,
  output logic dir
);
  localparam int CW = $clog2(PERIOD);

  logic [CW-1:0] cnt;
  logic          at_dir;
  logic          toggle_due;

  // DIR may only move on the STP falling edge: maximal setup and hold.
  assign at_dir = ena && (cnt == CW'(STEP_PULSE));

  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n) begin
      cnt <= '0;
      stp <= 1'b0;
    end else if (!ena) begin
      cnt <= '0;
      stp <= 1'b0;
    end else begin
      stp <= (cnt < CW'(STEP_PULSE));
      cnt <= (cnt == CW'(PERIOD - 1)) ? '0 : cnt + 1'b1;
    end

  generate
    if (TRAVEL > 0) begin : g_pp
      logic [15:0] steps;
      logic        pend;
      logic        at_rise;
      // cnt == 0 with ena set is exactly the edge that raises STP.
      assign at_rise = ena && (cnt == '0);
      always_ff @(posedge gclk or negedge grst_n)
        if (!grst_n) begin
          steps <= '0;
          pend  <= 1'b0;
        end else begin
          if (at_rise) begin
            if (steps == 16'(TRAVEL - 1)) begin
              steps <= '0;
              pend  <= 1'b1;
            end else begin
              steps <= steps + 1'b1;
            end
          end
          if (at_dir && pend) pend <= 1'b0;
        end
      assign toggle_due = pend;
    end else begin : g_fixed
      assign toggle_due = 1'b1;
    end
  endgenerate

  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n)                  dir <= 1'b0;
    else if (at_dir && toggle_due) dir <= (TRAVEL > 0) ? ~dir : dir_in;
endmodule

module rio_top #(
  parameter int BLINK_DIV  = 13_500_000,
  parameter int J8_PERIOD  = 2700,
  parameter int J9_PERIOD  = 5400,
  parameter int J10_PERIOD = 1350,
  parameter int STEP_PULSE = 54,
  parameter int J10_TRAVEL = 1000,
  parameter int DEB_CYCLES = 270_000
) (
  input  logic sysclk,
  input  logic sysrst_n,
  input  logic BUTTON1,
  input  logic BUTTON2,
  input  logic BUTTON3,
  output logic BLINK_LED,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4,
  output logic LED5,
  output logic DOUT11,
  output logic ENA,
  output logic JOINT8_STEPPER_STP,
  output logic JOINT8_STEPPER_DIR,
  output logic JOINT9_STEPPER_STP,
  output logic JOINT9_STEPPER_DIR,
  output logic JOINT10_STEPPER_STP,
  output logic JOINT10_STEPPER_DIR
);
  localparam int BW = $clog2(BLINK_DIV);

  logic [2:0]    btn_raw;
  logic [2:0]    b;
  logic [BW-1:0] blink_cnt;

  assign btn_raw = {BUTTON3, BUTTON2, BUTTON1};

  generate
    for (genvar i = 0; i < 3; i++) begin : g_btn
      rio_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
        .gclk   (sysclk),
        .grst_n (sysrst_n),
        .pin    (btn_raw[i]),
        .b      (b[i])
      );
    end
  endgenerate

  always_ff @(posedge sysclk or negedge sysrst_n)
    if (!sysrst_n) begin
      LED1   <= 1'b0;
      LED2   <= 1'b0;
      LED3   <= 1'b0;
      DOUT11 <= 1'b0;
      ENA    <= 1'b0;
    end else begin
      LED1   <= b[0];
      LED2   <= b[1];
      LED3   <= b[2];
      DOUT11 <= b[1] & b[2];
      ENA    <= ~b[0];
    end

  always_ff @(posedge sysclk or negedge sysrst_n)
    if (!sysrst_n) begin
      blink_cnt <= '0;
      BLINK_LED <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      BLINK_LED <= ~BLINK_LED;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end

  rio_stepgen #(.PERIOD(J8_PERIOD), .STEP_PULSE(STEP_PULSE), .TRAVEL(0)) u_j8 (
    .gclk (sysclk), .grst_n (sysrst_n), .ena (ENA), .dir_in (b[1]),
    .stp  (JOINT8_STEPPER_STP), .dir (JOINT8_STEPPER_DIR)
  );

  rio_stepgen #(.PERIOD(J9_PERIOD), .STEP_PULSE(STEP_PULSE), .TRAVEL(0)) u_j9 (
    .gclk (sysclk), .grst_n (sysrst_n), .ena (ENA), .dir_in (b[2]),
    .stp  (JOINT9_STEPPER_STP), .dir (JOINT9_STEPPER_DIR)
  );

  rio_stepgen #(.PERIOD(J10_PERIOD), .STEP_PULSE(STEP_PULSE), .TRAVEL(J10_TRAVEL)) u_j10 (
    .gclk (sysclk), .grst_n (sysrst_n), .ena (ENA), .dir_in (1'b0),
    .stp  (JOINT10_STEPPER_STP), .dir (JOINT10_STEPPER_DIR)
  );

  assign LED4 = ENA;
  assign LED5 = JOINT10_STEPPER_DIR;
endmodule

// File: tb/tb_rio_top.sv
// Directed bench for rio_top with shortened periods so every behaviour is
// reachable in a few thousand cycles.
module tb_rio_top;
  logic sysclk = 1'b0;
  logic sysrst_n = 1'b0;
  logic BUTTON1 = 1'b0, BUTTON2 = 1'b0, BUTTON3 = 1'b0;
  logic BLINK_LED, LED1, LED2, LED3, LED4, LED5, DOUT11, ENA;
  logic STP8, DIR8, STP9, DIR9, STP10, DIR10;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  rio_top #(
    .BLINK_DIV(1000), .J8_PERIOD(100), .J9_PERIOD(200), .J10_PERIOD(40),
    .STEP_PULSE(10), .J10_TRAVEL(5), .DEB_CYCLES(16)
  ) dut (
    .sysclk(sysclk), .sysrst_n(sysrst_n),
    .BUTTON1(BUTTON1), .BUTTON2(BUTTON2), .BUTTON3(BUTTON3),
    .BLINK_LED(BLINK_LED), .LED1(LED1), .LED2(LED2), .LED3(LED3),
    .LED4(LED4), .LED5(LED5), .DOUT11(DOUT11), .ENA(ENA),
    .JOINT8_STEPPER_STP(STP8), .JOINT8_STEPPER_DIR(DIR8),
    .JOINT9_STEPPER_STP(STP9), .JOINT9_STEPPER_DIR(DIR9),
    .JOINT10_STEPPER_STP(STP10), .JOINT10_STEPPER_DIR(DIR10)
  );

  always #5 sysclk = ~sysclk;

  // Rising edges since reset release.
  always @(posedge sysclk) if (!sysrst_n) cyc <= 0; else cyc <= cyc + 1;

  task automatic tick();
    @(negedge sysclk);
  endtask

  task automatic test_reset();
    logic [13:0] outs;
    sysrst_n = 1'b0;
    repeat (10) tick();
    outs = {BLINK_LED, LED1, LED2, LED3, LED4, LED5, DOUT11, ENA,
            STP8, DIR8, STP9, DIR9, STP10, DIR10};
    checks++;
    if (outs !== 14'h0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0", outs);
    end
    sysrst_n = 1'b1;
    tick();
    checks++;
    if (ENA !== 1'b1 || LED4 !== 1'b1 || STP8 !== 1'b0) begin
      errors++; $display("FAIL ena_after_reset: ENA=%b LED4=%b STP8=%b expected 1 1 0", ENA, LED4, STP8);
    end
    tick();
    checks++;
    if (STP8 !== 1'b1 || STP9 !== 1'b1 || STP10 !== 1'b1) begin
      errors++; $display("FAIL first_step: STP8/9/10=%b%b%b expected 111", STP8, STP9, STP10);
    end
  endtask

  // Entered on the first sample where STP8 is high.
  task automatic test_step8();
    int h, l;
    h = 0; l = 0;
    while (STP8 === 1'b1 && h < 500) begin h++; tick(); end
    while (STP8 === 1'b0 && l < 500) begin l++; tick(); end
    checks++;
    if (h != 10 || l != 90) begin
      errors++; $display("FAIL stp8_shape: high=%0d low=%0d expected 10 90", h, l);
    end
    checks++;
    if (DIR8 !== 1'b0) begin
      errors++; $display("FAIL dir8_idle: got %b expected 0", DIR8);
    end
  endtask

  // Entered on the first high sample of an STP8 pulse.
  task automatic test_dir8();
    logic prev_stp, prev_dir;
    int n;
    BUTTON2 = 1'b1;
    tick(); tick();
    checks++;
    if (LED2 !== 1'b0) begin
      errors++; $display("FAIL led2_early: got %b expected 0", LED2);
    end
    tick();
    checks++;
    if (LED2 !== 1'b1 || DOUT11 !== 1'b0) begin
      errors++; $display("FAIL led2_latency: LED2=%b DOUT11=%b expected 1 0", LED2, DOUT11);
    end
    prev_dir = DIR8; prev_stp = STP8; n = 0;
    while (DIR8 === prev_dir && n < 300) begin prev_stp = STP8; tick(); n++; end
    checks++;
    if (DIR8 !== 1'b1 || STP8 !== 1'b0 || prev_stp !== 1'b1 || n != 7) begin
      errors++; $display("FAIL dir8_edge: DIR8=%b STP8=%b prevSTP=%b n=%0d expected 1 0 1 7",
                         DIR8, STP8, prev_stp, n);
    end
    BUTTON3 = 1'b1;
    repeat (3) tick();
    checks++;
    if (LED3 !== 1'b1 || DOUT11 !== 1'b1) begin
      errors++; $display("FAIL led3_dout11: LED3=%b DOUT11=%b expected 1 1", LED3, DOUT11);
    end
    prev_stp = STP9; n = 0;
    while (DIR9 !== 1'b1 && n < 400) begin prev_stp = STP9; tick(); n++; end
    checks++;
    if (DIR9 !== 1'b1 || STP9 !== 1'b0 || prev_stp !== 1'b1) begin
      errors++; $display("FAIL dir9_edge: DIR9=%b STP9=%b prevSTP=%b expected 1 0 1", DIR9, STP9, prev_stp);
    end
  endtask

  task automatic test_stop();
    bit moved;
    int h;
    BUTTON1 = 1'b1;
    repeat (3) tick();
    checks++;
    if (ENA !== 1'b0) begin
      errors++; $display("FAIL ena_drop: got %b expected 0", ENA);
    end
    tick();
    checks++;
    if ({STP8, STP9, STP10} !== 3'b000 || LED4 !== 1'b0 || LED1 !== 1'b1) begin
      errors++; $display("FAIL stop_outputs: STP=%b%b%b LED4=%b LED1=%b expected 000 0 1",
                         STP8, STP9, STP10, LED4, LED1);
    end
    moved = 1'b0;
    repeat (20) begin tick(); if (STP8 !== 1'b0 || STP10 !== 1'b0) moved = 1'b1; end
    checks++;
    if (moved) begin
      errors++; $display("FAIL stop_hold: got step activity expected none");
    end
    BUTTON1 = 1'b0;
    repeat (3) tick();
    checks++;
    if (ENA !== 1'b1 || STP8 !== 1'b0) begin
      errors++; $display("FAIL ena_resume: ENA=%b STP8=%b expected 1 0", ENA, STP8);
    end
    tick();
    h = 0;
    while (STP8 === 1'b1 && h < 500) begin h++; tick(); end
    checks++;
    if (h != 10) begin
      errors++; $display("FAIL resume_pulse: high=%0d expected 10", h);
    end
  endtask

  task automatic test_j10();
    logic v, prev;
    int n, rises, t0;
    bit early;
    v = DIR10; n = 0;
    while (DIR10 === v && n < 2000) begin tick(); n++; end
    v = DIR10; t0 = cyc;
    rises = 0; early = 1'b0; prev = STP10; n = 0;
    while (rises < 5 && n < 1000) begin
      tick(); n++;
      if (STP10 === 1'b1 && prev === 1'b0) rises++;
      if (DIR10 !== v) early = 1'b1;
      prev = STP10;
    end
    n = 0;
    while (STP10 === 1'b1 && n < 50) begin
      if (DIR10 !== v) early = 1'b1;
      tick(); n++;
    end
    checks++;
    if (early || DIR10 !== ~v || LED5 !== ~v) begin
      errors++; $display("FAIL j10_toggle: early=%b DIR10=%b LED5=%b expected 0 %b %b",
                         early, DIR10, LED5, ~v, ~v);
    end
    checks++;
    if (cyc - t0 != 200) begin
      errors++; $display("FAIL j10_sweep_time: got %0d cycles expected 200", cyc - t0);
    end
  endtask

  task automatic test_blink();
    logic v;
    int n, t0;
    v = BLINK_LED; n = 0;
    while (BLINK_LED === v && n < 1100) begin tick(); n++; end
    t0 = cyc;
    checks++;
    if (BLINK_LED === v || (t0 % 1000) != 0) begin
      errors++; $display("FAIL blink_phase: toggle at cycle %0d expected a multiple of 1000", t0);
    end
    v = BLINK_LED; n = 0;
    while (BLINK_LED === v && n < 1100) begin tick(); n++; end
    checks++;
    if (cyc - t0 != 1000) begin
      errors++; $display("FAIL blink_half_period: got %0d expected 1000", cyc - t0);
    end
  endtask

  task automatic test_debounce();
    bit seen;
    int n;
    BUTTON3 = 1'b1;
    repeat (8) tick();
    BUTTON3 = 1'b0;
    seen = 1'b0;
    repeat (40) begin tick(); if (LED3 !== 1'b0) seen = 1'b1; end
    checks++;
    if (seen) begin
      errors++; $display("FAIL glitch_filtered: LED3 pulsed expected steady 0");
    end
    BUTTON3 = 1'b1;
    n = 0;
    while (LED3 !== 1'b1 && n < 60) begin tick(); n++; end
    checks++;
    if (n != 19) begin
      errors++; $display("FAIL debounce_latency: got %0d clocks expected 19", n);
    end
  endtask

  initial begin
    test_reset();
`ifdef RIO_DEBOUNCE_EN
    test_debounce();
`else
    test_step8();
    test_dir8();
    test_stop();
    test_j10();
    test_blink();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
